// File: rtl/stage_status_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : stage_status_tx_if
// Description : Write handshake, error strobe and pad-side signals of the
//               6-bit test-status transmitter.
// Revision    : 1.0
// ============================================================================
interface stage_status_tx_if #(
    parameter int FIFO_DEPTH = 4
) ();
    localparam int C_LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic               wr_valid_i;
    logic [4:0]         wr_stage_i;
    logic               wr_ready_o;
    logic               err_i;
    logic [5:0]         status_o;
    logic [5:0]         status_oeb_o;
    logic               busy_o;
    logic [C_LVL_W-1:0] fifo_level_o;

    modport master (
        output wr_valid_i,
        output wr_stage_i,
        output err_i,
        input  wr_ready_o,
        input  status_o,
        input  status_oeb_o,
        input  busy_o,
        input  fifo_level_o
    );

    modport slave (
        input  wr_valid_i,
        input  wr_stage_i,
        input  err_i,
        output wr_ready_o,
        output status_o,
        output status_oeb_o,
        output busy_o,
        output fifo_level_o
    );
endinterface
`default_nettype wire

// File: rtl/stage_status_tx.sv
`default_nettype none
// ============================================================================
// Module      : stage_status_tx
// Description : Queues 5-bit stage codes and drives them onto the status pads,
//               holding each for a minimum time, with sticky error and pass.
// Revision    : 1.0
// ============================================================================
module stage_status_tx #(
    parameter int         HOLD_CYCLES = 128,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [4:0] PASS_CODE   = 5'd30
) (
    input  wire logic          wb_clk_i,
    input  wire logic          wb_rst_i,
    stage_status_tx_if.slave   bus
);
    localparam int          C_AW        = $clog2(FIFO_DEPTH);
    localparam int          C_LVL_W     = C_AW + 1;
    localparam logic [15:0] C_HOLD_LOAD = 16'(HOLD_CYCLES - 1);
    localparam logic [C_LVL_W-1:0] C_FULL = C_LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          stage_q, stage_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [C_AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [C_AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [C_LVL_W-1:0]  level_q, level_d;
    logic [4:0]          fifo_mem_q [FIFO_DEPTH];

    logic                w_full;
    logic                w_ready;
    logic                w_push;
    logic                w_pop;
    logic [4:0]          w_head;

    always_comb begin
        w_full  = (level_q == C_FULL);
        w_ready = !w_full && (state_q != ST_ERROR) && (state_q != ST_DONE) && !bus.err_i;
        w_push  = bus.wr_valid_i && w_ready;
        w_pop   = (state_q == ST_IDLE) && (level_q != '0) && !bus.err_i;
        w_head  = fifo_mem_q[rd_ptr_q];
    end

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;

        if (bus.err_i) begin
            // Error wins over everything: flush the queue, freeze the stage.
            state_d  = ST_ERROR;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (w_pop) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        // A repeat of the shown code would be invisible to the monitor.
                        if (w_head != stage_q) begin
                            stage_d = w_head;
                            cnt_d   = C_HOLD_LOAD;
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        state_d = (stage_q == PASS_CODE) ? ST_DONE : ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DONE:  state_d = ST_DONE;
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_IDLE;
            endcase

            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            level_d = level_q + C_LVL_W'(w_push) - C_LVL_W'(w_pop);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            stage_q  <= '0;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= bus.wr_stage_i;
        end
    end

    assign bus.wr_ready_o   = w_ready;
    assign bus.status_o     = {(state_q == ST_ERROR), stage_q};
    assign bus.status_oeb_o = 6'b000000;
    assign bus.busy_o       = (state_q != ST_DONE) && (state_q != ST_ERROR) &&
                              ((level_q != '0) || (state_q == ST_HOLD));
    assign bus.fifo_level_o = level_q;

endmodule
`default_nettype wire
